// File: rtl/sw_led_ctrl.sv
// sw_led_ctrl: debounced switch-driven LED mode controller.
// A raw switch is synchronized and debounced. Each accepted rising edge
// advances the LED mode OFF -> ON -> BLINK -> DIM -> OFF. The LED output is
// registered and derived from the mode held before each clock edge.
module sw_led_ctrl #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [23:0] BLINK_HALF      = 24'd12500000,
   parameter logic [3:0]  DIM_DUTY        = 4'd4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       SW,
   output logic       LED,
   output logic [1:0] mode,
   output logic       press,
   output logic       sw_clean
);

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_ON    = 2'd1;
   localparam logic [1:0] MODE_BLINK = 2'd2;
   localparam logic [1:0] MODE_DIM   = 2'd3;

   // registered state
   logic        s1_r;
   logic        s2_r;
   logic        sw_clean_r;
   logic [15:0] db_cnt_r;
   logic        press_r;
   logic [1:0]  mode_r;
   logic [23:0] blink_cnt_r;
   logic        phase_r;
   logic [3:0]  pwm_cnt_r;
   logic        led_r;

   // next-state values
   logic        sw_clean_s;
   logic [15:0] db_cnt_s;
   logic        rise_s;
   logic [1:0]  mode_s;
   logic [23:0] blink_cnt_s;
   logic        phase_s;
   logic [3:0]  pwm_cnt_s;
   logic        led_s;

   // Debounce: count consecutive cycles the synchronized level differs
   // from the accepted level; accept it once the count reaches the limit.
   always_comb begin
      sw_clean_s = sw_clean_r;
      db_cnt_s   = 16'd0;
      rise_s     = 1'b0;
      if (s2_r == sw_clean_r) begin
         db_cnt_s = 16'd0;
      end else if (db_cnt_r == (DEBOUNCE_CYCLES - 16'd1)) begin
         sw_clean_s = s2_r;
         db_cnt_s   = 16'd0;
         rise_s     = s2_r;
      end else begin
         db_cnt_s = db_cnt_r + 16'd1;
      end
   end

   // Mode sequencing: advance one step (wrapping) on each accepted press.
   always_comb begin
      mode_s = mode_r;
      if (rise_s) begin
         mode_s = mode_r + 2'd1;
      end else begin
         mode_s = mode_r;
      end
   end

   // Blink timer: runs only while staying in BLINK; restarts at phase 1
   // whenever BLINK is entered or left.
   always_comb begin
      blink_cnt_s = 24'd0;
      phase_s     = 1'b1;
      if ((mode_r == MODE_BLINK) && (mode_s == MODE_BLINK)) begin
         if (blink_cnt_r == (BLINK_HALF - 24'd1)) begin
            blink_cnt_s = 24'd0;
            phase_s     = ~phase_r;
         end else begin
            blink_cnt_s = blink_cnt_r + 24'd1;
            phase_s     = phase_r;
         end
      end else begin
         blink_cnt_s = 24'd0;
         phase_s     = 1'b1;
      end
   end

   // PWM counter free-runs in every mode so DIM phase is arbitrary.
   always_comb begin
      pwm_cnt_s = pwm_cnt_r + 4'd1;
   end

   // LED drive selected by the mode held before this edge.
   always_comb begin
      led_s = 1'b0;
      case (mode_r)
         MODE_OFF:   led_s = 1'b0;
         MODE_ON:    led_s = 1'b1;
         MODE_BLINK: led_s = phase_r;
         MODE_DIM:   led_s = (pwm_cnt_r < DIM_DUTY);
         default:    led_s = 1'b0;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_r        <= 1'b0;
         s2_r        <= 1'b0;
         sw_clean_r  <= 1'b0;
         db_cnt_r    <= 16'd0;
         press_r     <= 1'b0;
         mode_r      <= MODE_OFF;
         blink_cnt_r <= 24'd0;
         phase_r     <= 1'b1;
         pwm_cnt_r   <= 4'd0;
         led_r       <= 1'b0;
      end else begin
         s1_r        <= SW;
         s2_r        <= s1_r;
         sw_clean_r  <= sw_clean_s;
         db_cnt_r    <= db_cnt_s;
         press_r     <= rise_s;
         mode_r      <= mode_s;
         blink_cnt_r <= blink_cnt_s;
         phase_r     <= phase_s;
         pwm_cnt_r   <= pwm_cnt_s;
         led_r       <= led_s;
      end
   end

   assign LED      = led_r;
   assign mode     = mode_r;
   assign press    = press_r;
   assign sw_clean = sw_clean_r;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// tb_sw_led_ctrl: directed stimulus against a cycle-level behavioural model,
// with literal expectations at the key points of each scenario.
module tb_sw_led_ctrl;

   localparam int D    = 4;
   localparam int BH   = 3;
   localparam int DUTY = 4;

   logic       clk;
   logic       rst_n;
   logic       SW;
   logic       LED;
   logic [1:0] mode;
   logic       press;
   logic       sw_clean;

   sw_led_ctrl #(
      .DEBOUNCE_CYCLES(16'd4),
      .BLINK_HALF     (24'd3),
      .DIM_DUTY       (4'd4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .SW      (SW),
      .LED     (LED),
      .mode    (mode),
      .press   (press),
      .sw_clean(sw_clean)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: outputs expected just after each rising edge
   int  m_s1, m_s2;
   int  hist[$];
   bit  m_clean, m_press, m_led, m_valid, acc, new_led;
   int  m_mode, blink_k, pwm_n;

   initial m_valid = 1'b0;

   // Model: clean level flips once the last D synchronized samples all
   // disagree with it; mode counts accepted rises mod 4.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_s1 = 0; m_s2 = 0; hist.delete();
         m_clean = 0; m_press = 0; m_led = 0; m_mode = 0;
         blink_k = 0; pwm_n = 0; m_valid = 1'b1;
      end else begin
         hist.push_back(m_s2);
         if (hist.size() > D) void'(hist.pop_front());
         acc = (hist.size() == D);
         foreach (hist[i]) if (hist[i] == int'(m_clean)) acc = 1'b0;
         case (m_mode)
            0: new_led = 1'b0;
            1: new_led = 1'b1;
            2: begin
               blink_k++;
               new_led = (((blink_k - 1) / BH) % 2) == 0;
            end
            default: new_led = ((pwm_n % 16) < DUTY);
         endcase
         pwm_n++;
         m_press = 1'b0;
         if (acc) begin
            m_clean = !m_clean;
            hist.delete();
            if (m_clean) begin
               m_press = 1'b1;
               m_mode  = (m_mode + 1) % 4;
               if (m_mode == 2) blink_k = 0;
            end
         end
         m_led = new_led;
         m_s2 = m_s1;
         m_s1 = int'(SW);
      end
   end

   // Compare every cycle once the model has seen a reset.
   always @(posedge clk) begin
      #1;
      if (m_valid) begin
         chk("model_led", LED, m_led);
         chk("model_mode", mode, m_mode);
         chk("model_press", press, m_press);
         chk("model_sw_clean", sw_clean, m_clean);
      end
   end

   bit pat[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   int hi;

   task automatic release_sw();
      @(negedge clk) SW = 1'b0;
      repeat (8) @(posedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      SW    = 1'b1;
      // reset held 3 edges with SW high
      repeat (3) begin
         @(posedge clk); #2;
         chk("rst_led", LED, 0);
         chk("rst_mode", mode, 0);
         chk("rst_press", press, 0);
         chk("rst_clean", sw_clean, 0);
      end
      @(negedge clk) rst_n = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #2;
         if (i == 5) begin
            chk("post_rst_clean5", sw_clean, 0);
            chk("post_rst_mode5", mode, 0);
         end
         if (i == 6) begin
            chk("post_rst_clean6", sw_clean, 1);
            chk("post_rst_mode6", mode, 1);
            chk("post_rst_press6", press, 1);
         end
      end
      // release only
      @(negedge clk) SW = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #2;
         chk("release_press", press, 0);
         if (i == 6) begin
            chk("release_clean", sw_clean, 0);
            chk("release_mode", mode, 1);
         end
      end
      repeat (3) @(posedge clk);
      // back to OFF
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      // glitch of 3 cycles
      @(negedge clk) SW = 1'b1;
      repeat (3) @(negedge clk);
      SW = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #2;
         chk("glitch_press", press, 0);
         chk("glitch_clean", sw_clean, 0);
         chk("glitch_mode", mode, 0);
      end
      // clean press -> ON
      @(negedge clk) SW = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         @(posedge clk); #2;
         if (i == 5) chk("press_early", press, 0);
         if (i == 6) begin
            chk("press_pulse", press, 1);
            chk("press_mode_on", mode, 1);
         end
         if (i == 7) begin
            chk("press_one_cycle", press, 0);
            chk("on_led", LED, 1);
         end
      end
      release_sw();
      // press -> BLINK, pattern 1,1,1,0,0,0
      @(negedge clk) SW = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #2;
         if (i == 6) chk("blink_mode", mode, 2);
         if (i >= 7) chk("blink_pat", LED, pat[i - 7]);
      end
      release_sw();
      // press -> DIM, 4 high out of 16
      @(negedge clk) SW = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #2;
         if (i == 6) chk("dim_mode", mode, 3);
      end
      hi = 0;
      for (int j = 0; j < 16; j++) begin
         @(posedge clk); #2;
         hi += int'(LED);
      end
      chk("dim_duty", hi, 4);
      release_sw();
      // press -> OFF
      @(negedge clk) SW = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         @(posedge clk); #2;
         if (i == 6) chk("wrap_mode", mode, 0);
         if (i == 7) chk("off_led", LED, 0);
      end
      release_sw();
      // ON, then BLINK, then reset while phase is 0
      @(negedge clk) SW = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #2;
         if (i == 6) chk("mid_on_mode", mode, 1);
      end
      release_sw();
      @(negedge clk) SW = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         @(posedge clk); #2;
         if (i == 6) chk("mid_blink_mode", mode, 2);
         if (i == 9) chk("mid_blink_led", LED, 1);
      end
      @(negedge clk) begin
         rst_n = 1'b0;
         SW    = 1'b0;
      end
      @(posedge clk); #2;
      chk("midrst_mode", mode, 0);
      chk("midrst_led", LED, 0);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #2;
         chk("after_rst_press", press, 0);
         chk("after_rst_led", LED, 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
